// File: rtl/tl_ram_arbiter_pkg.sv
// Shared types for the two-requester TileLink RAM arbiter: FSM state, port index,
// bus widths and the TL-UL opcode values carried on the A channel.
package tl_arb_pkg;

   localparam int unsigned TL_AW  = 32;
   localparam int unsigned TL_DW  = 32;
   localparam int unsigned TL_OPW = 3;

   localparam logic [TL_OPW-1:0] TL_OP_PUT_FULL    = 3'd0;
   localparam logic [TL_OPW-1:0] TL_OP_PUT_PARTIAL = 3'd1;
   localparam logic [TL_OPW-1:0] TL_OP_GET         = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      A_PHASE = 2'd1,
      D_PHASE = 2'd2
   } arb_state_e;

   typedef logic port_idx_t;

endpackage

// File: rtl/tl_ram_arbiter_if.sv
// Minimal TileLink-UL style channel: A request with valid/ready, single-beat D response.
interface tilelink
   import tl_arb_pkg::*;
   ();

   logic              a_valid;
   logic              a_ready;
   logic [TL_OPW-1:0] a_opcode;
   logic [TL_AW-1:0]  a_address;
   logic [TL_DW-1:0]  a_data;
   logic              d_valid;
   logic              d_ready;
   logic [TL_DW-1:0]  d_data;

   modport master (
      output a_valid, a_opcode, a_address, a_data, d_ready,
      input  a_ready, d_valid, d_data
   );

   modport slave (
      input  a_valid, a_opcode, a_address, a_data, d_ready,
      output a_ready, d_valid, d_data
   );

endinterface

// File: rtl/tl_ram_arbiter_rr_pick.sv
// Two-input grant picker: round-robin against the last-granted pointer, or m0-first.
module rr_pick
   import tl_arb_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [1:0] req,
   input  port_idx_t  last,
   output port_idx_t  gnt
);

   always_comb begin
      gnt = 1'b0;
      if (!FIXED_PRIO && req == 2'b11) begin
         gnt = ~last;
      end else begin
         gnt = req[0] ? 1'b0 : 1'b1;
      end
   end

endmodule

// File: rtl/tl_ram_arbiter.sv
// Arbitrates two TileLink requesters onto one RAM channel, one transaction outstanding,
// with an idle bubble between transactions.
module tl_ram_arbiter
   import tl_arb_pkg::*;
#(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic   clk,
   input  logic   rst_n,
   tilelink.slave  m0,
   tilelink.slave  m1,
   tilelink.master ram
);

   arb_state_e state;
   port_idx_t  gnt;
   port_idx_t  last;
   port_idx_t  pick;
   logic [1:0] req;
   logic       gnt_a_valid;
   logic       gnt_d_ready;

   assign req = {m1.a_valid, m0.a_valid};

   rr_pick #(
      .FIXED_PRIO(FIXED_PRIO != 0)
   ) u_rr_pick (
      .req (req),
      .last(last),
      .gnt (pick)
   );

   always_comb begin
      gnt_a_valid = gnt ? m1.a_valid : m0.a_valid;
      gnt_d_ready = gnt ? m1.d_ready : m0.d_ready;
   end

   // Pointer updates on every grant, even one later abandoned in A_PHASE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt   <= pick;
                  last  <= pick;
                  state <= A_PHASE;
               end
            end
            A_PHASE: begin
               if (!gnt_a_valid) begin
                  state <= IDLE;
               end else if (ram.a_ready) begin
                  state <= D_PHASE;
               end
            end
            D_PHASE: begin
               if (ram.d_valid && gnt_d_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      ram.a_valid   = 1'b0;
      ram.a_opcode  = gnt ? m1.a_opcode  : m0.a_opcode;
      ram.a_address = gnt ? m1.a_address : m0.a_address;
      ram.a_data    = gnt ? m1.a_data    : m0.a_data;
      ram.d_ready   = 1'b0;
      m0.a_ready    = 1'b0;
      m1.a_ready    = 1'b0;
      m0.d_valid    = 1'b0;
      m1.d_valid    = 1'b0;
      m0.d_data     = ram.d_data;
      m1.d_data     = ram.d_data;
      case (state)
         A_PHASE: begin
            ram.a_valid = gnt_a_valid;
            if (gnt) m1.a_ready = ram.a_ready;
            else     m0.a_ready = ram.a_ready;
         end
         D_PHASE: begin
            ram.d_ready = gnt_d_ready;
            if (gnt) m1.d_valid = ram.d_valid;
            else     m0.d_valid = ram.d_valid;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tl_ram_arbiter.sv
// Bench for tl_ram_arbiter: transaction-level reference model with random requesters
// and RAM responder, plus directed scenarios and a fixed-priority instance.
module tb_tl_ram_arbiter;
   import tl_arb_pkg::*;

   localparam int M_IDLE = 0;
   localparam int M_A    = 1;
   localparam int M_D    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tilelink m0_if ();
   tilelink m1_if ();
   tilelink ram_if ();
   tilelink fp_m0 ();
   tilelink fp_m1 ();
   tilelink fp_ram ();

   tl_ram_arbiter #(.FIXED_PRIO(0)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .m0   (m0_if),
      .m1   (m1_if),
      .ram  (ram_if)
   );

   tl_ram_arbiter #(.FIXED_PRIO(1)) u_dut_fp (
      .clk  (clk),
      .rst_n(rst_n),
      .m0   (fp_m0),
      .m1   (fp_m1),
      .ram  (fp_ram)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // requester side
   bit          pend [2];
   logic [2:0]  rq_op [2];
   logic [31:0] rq_addr [2];
   logic [31:0] rq_data [2];
   int          req_left [2];
   bit          d_rdy [2];
   int          d_rdy_mode [2];
   bit          rnd_gen = 0;
   int          drop_pct = 0;
   // ram responder
   bit          a_rdy = 0;
   int          a_rdy_mode = -1;
   bit          rsp_busy = 0;
   int          rsp_delay = 0;
   int          delay_mode = -1;
   bit          rsp_fixed_en = 0;
   logic [31:0] rsp_fixed = '0;
   logic [31:0] rsp_cur = '0;
   bit          dv = 0;
   // transaction model
   int          mph = M_IDLE;
   int          win = 0;
   int          served[$];
   logic [31:0] exp_rsp = '0;
   int          done_cnt = 0;
   int          last_d_port = -1;
   logic [31:0] last_d_data = '0;
   int          a_valid_cnt = 0;
   int          m1_dv_cnt = 0;
   int          fp_hs = 0;
   int          fp_m1_gnt = 0;

   function automatic logic [31:0] rsp_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] d);
      return a ^ {d[15:0], d[31:16]} ^ {29'd0, op} ^ 32'h5A5A_1234;
   endfunction

   function automatic logic m_a_ready(input int p);
      return (p != 0) ? m1_if.a_ready : m0_if.a_ready;
   endfunction

   function automatic logic m_d_valid(input int p);
      return (p != 0) ? m1_if.d_valid : m0_if.d_valid;
   endfunction

   function automatic logic [31:0] m_d_data(input int p);
      return (p != 0) ? m1_if.d_data : m0_if.d_data;
   endfunction

   task automatic drive_all();
      m0_if.a_valid   = pend[0];
      m0_if.a_opcode  = rq_op[0];
      m0_if.a_address = rq_addr[0];
      m0_if.a_data    = rq_data[0];
      m0_if.d_ready   = d_rdy[0];
      m1_if.a_valid   = pend[1];
      m1_if.a_opcode  = rq_op[1];
      m1_if.a_address = rq_addr[1];
      m1_if.a_data    = rq_data[1];
      m1_if.d_ready   = d_rdy[1];
      ram_if.a_ready  = a_rdy;
      ram_if.d_valid  = dv;
      ram_if.d_data   = rsp_cur;
   endtask

   task automatic new_req(input int p);
      pend[p]    = 1'b1;
      rq_op[p]   = 3'($urandom_range(7));
      rq_addr[p] = ($urandom & 32'hFFFF_FFF8) | (p != 0 ? 32'd4 : 32'd0);
      rq_data[p] = $urandom;
   endtask

   task automatic issue_req(input int p, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] data);
      pend[p]    = 1'b1;
      rq_op[p]   = op;
      rq_addr[p] = addr;
      rq_data[p] = data;
      drive_all();
   endtask

   task automatic clear_model();
      mph = M_IDLE;
      rsp_busy = 0;
      dv = 0;
      a_rdy = 0;
      served.delete();
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0;
         req_left[p] = 0;
         d_rdy[p] = 0;
      end
   endtask

   // One clock: check at negedge against the model, then advance model and stimulus.
   task automatic tick();
      bit start, a_hs, d_hs, abort_a;
      int o;
      logic [2:0]  s_op;
      logic [31:0] s_addr, s_data;
      start = 0; a_hs = 0; d_hs = 0; abort_a = 0;
      @(negedge clk);
      s_op = ram_if.a_opcode;
      s_addr = ram_if.a_address;
      s_data = ram_if.a_data;
      if (ram_if.a_valid) a_valid_cnt++;
      if (m1_if.d_valid) m1_dv_cnt++;
      if (rst_n) begin
         if (fp_ram.a_valid && fp_ram.a_ready) fp_hs++;
         if ((fp_ram.a_valid && fp_ram.a_address == 32'h0000_2000) || fp_m1.a_ready || fp_m1.d_valid)
            fp_m1_gnt++;
      end
      o = 1 - win;
      case (mph)
         M_IDLE: begin
            check_eq("idle_ram_a_valid", 32'(ram_if.a_valid), 32'd0);
            check_eq("idle_ram_d_ready", 32'(ram_if.d_ready), 32'd0);
            check_eq("idle_a_ready", 32'({m1_if.a_ready, m0_if.a_ready}), 32'd0);
            check_eq("idle_d_valid", 32'({m1_if.d_valid, m0_if.d_valid}), 32'd0);
            if (pend[0] || pend[1]) begin
               if (pend[0] && pend[1]) win = (served.size() == 0) ? 0 : 1 - served[$];
               else                    win = pend[0] ? 0 : 1;
               start = 1;
            end
         end
         M_A: begin
            check_eq("a_ram_a_valid", 32'(ram_if.a_valid), 32'(pend[win]));
            if (pend[win]) begin
               check_eq("a_opcode", 32'(s_op), 32'(rq_op[win]));
               check_eq("a_address", s_addr, rq_addr[win]);
               check_eq("a_data", s_data, rq_data[win]);
            end
            check_eq("a_gnt_a_ready", 32'(m_a_ready(win)), 32'(a_rdy));
            check_eq("a_oth_a_ready", 32'(m_a_ready(o)), 32'd0);
            check_eq("a_d_valid", 32'({m1_if.d_valid, m0_if.d_valid}), 32'd0);
            check_eq("a_ram_d_ready", 32'(ram_if.d_ready), 32'd0);
            a_hs = pend[win] && a_rdy;
            abort_a = !pend[win];
         end
         default: begin
            check_eq("d_ram_a_valid", 32'(ram_if.a_valid), 32'd0);
            check_eq("d_a_ready", 32'({m1_if.a_ready, m0_if.a_ready}), 32'd0);
            check_eq("d_gnt_d_valid", 32'(m_d_valid(win)), 32'(dv));
            check_eq("d_oth_d_valid", 32'(m_d_valid(o)), 32'd0);
            check_eq("d_ram_d_ready", 32'(ram_if.d_ready), 32'(d_rdy[win]));
            d_hs = dv && d_rdy[win];
            if (d_hs) begin
               check_eq("d_resp_data", m_d_data(win), exp_rsp);
               done_cnt++;
               last_d_port = win;
               last_d_data = m_d_data(win);
            end
         end
      endcase
      @(posedge clk);
      #1;
      if (start) begin
         mph = M_A;
         served.push_back(win);
      end
      if (abort_a) mph = M_IDLE;
      if (a_hs) begin
         mph = M_D;
         pend[win] = 0;
         rsp_busy = 1;
         rsp_delay = (delay_mode < 0) ? $urandom_range(3) : delay_mode;
         rsp_cur = rsp_fixed_en ? rsp_fixed : rsp_fn(s_op, s_addr, s_data);
         exp_rsp = rsp_fixed_en ? rsp_fixed : rsp_fn(rq_op[win], rq_addr[win], rq_data[win]);
      end else if (d_hs) begin
         mph = M_IDLE;
         rsp_busy = 0;
      end else if (rsp_busy && rsp_delay > 0) begin
         rsp_delay--;
      end
      for (int p = 0; p < 2; p++) begin
         if (pend[p]) begin
            if (drop_pct > 0 && $urandom_range(99) < drop_pct) pend[p] = 0;
         end else if (req_left[p] > 0) begin
            new_req(p);
            req_left[p]--;
         end else if (rnd_gen && $urandom_range(1) == 1) begin
            new_req(p);
         end
         d_rdy[p] = (d_rdy_mode[p] < 0) ? ($urandom_range(3) != 0) : (d_rdy_mode[p] != 0);
      end
      a_rdy = (a_rdy_mode < 0) ? ($urandom_range(1) == 1) : (a_rdy_mode != 0);
      dv = rsp_busy && rsp_delay == 0;
      if (!rsp_busy) rsp_cur = $urandom;
      drive_all();
   endtask

   task automatic run_until_done(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic run_until_phase(input int ph, input int budget, input string tag);
      int n = 0;
      while (mph != ph && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(mph == ph), 32'd1);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      clear_model();
      drive_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      fp_m0.a_valid = 1'b1;  fp_m0.a_opcode = TL_OP_GET;      fp_m0.a_address = 32'h0000_1000;
      fp_m0.a_data  = '0;    fp_m0.d_ready  = 1'b1;
      fp_m1.a_valid = 1'b1;  fp_m1.a_opcode = TL_OP_PUT_FULL; fp_m1.a_address = 32'h0000_2000;
      fp_m1.a_data  = '1;    fp_m1.d_ready  = 1'b1;
      fp_ram.a_ready = 1'b1; fp_ram.d_valid = 1'b1;           fp_ram.d_data = 32'hCAFE_F00D;
   end

   initial begin
      int base;
      for (int p = 0; p < 2; p++) begin
         d_rdy_mode[p] = -1;
         rq_op[p] = '0;
         rq_addr[p] = '0;
         rq_data[p] = '0;
      end
      clear_model();
      drive_all();

      // reset values
      @(negedge clk);
      check_eq("rst_ram_a_valid", 32'(ram_if.a_valid), 32'd0);
      check_eq("rst_ram_d_ready", 32'(ram_if.d_ready), 32'd0);
      check_eq("rst_a_ready", 32'({m1_if.a_ready, m0_if.a_ready}), 32'd0);
      check_eq("rst_d_valid", 32'({m1_if.d_valid, m0_if.d_valid}), 32'd0);
      apply_reset();

      // single Get from m0 with fixed response
      a_rdy_mode = 1; delay_mode = 2; rsp_fixed_en = 1; rsp_fixed = 32'hDEAD_BEEF;
      d_rdy_mode[0] = 1; d_rdy_mode[1] = 1;
      m1_dv_cnt = 0;
      issue_req(0, TL_OP_GET, 32'h8000_0000, 32'h0);
      base = done_cnt;
      run_until_done(base + 1, 20, "get_done");
      check_eq("get_port", 32'(last_d_port), 32'd0);
      check_eq("get_data", last_d_data, 32'hDEAD_BEEF);
      check_eq("get_m1_no_dvalid", 32'(m1_dv_cnt), 32'd0);
      rsp_fixed_en = 0;

      // alternation after reset, 4 requests per port
      apply_reset();
      a_rdy_mode = -1; delay_mode = -1; d_rdy_mode[0] = -1; d_rdy_mode[1] = -1;
      req_left[0] = 4; req_left[1] = 4;
      base = done_cnt;
      run_until_done(base + 8, 200, "rr_done");
      check_eq("rr_served_cnt", 32'(served.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < served.size()) check_eq("rr_order", 32'(served[i]), 32'(i % 2));
      end

      // a_ready withheld for five cycles
      a_rdy_mode = 0;
      tick();
      issue_req(0, TL_OP_PUT_PARTIAL, 32'h0000_0040, 32'h1234_5678);
      a_valid_cnt = 0;
      repeat (6) tick();
      check_eq("stall_a_valid_cycles", 32'(a_valid_cnt), 32'd5);
      check_eq("stall_no_d", 32'(mph), 32'(M_A));
      a_rdy_mode = 1;
      base = done_cnt;
      run_until_done(base + 1, 30, "stall_done");

      // D backpressure from m1 while m0 waits
      delay_mode = 0; d_rdy_mode[1] = 0;
      issue_req(1, TL_OP_GET, 32'h0000_0104, 32'h0);
      run_until_phase(M_D, 20, "bp_reach_d");
      issue_req(0, TL_OP_GET, 32'h0000_0200, 32'h0);
      base = done_cnt;
      repeat (3) tick();
      #1;
      check_eq("bp_no_done", 32'(done_cnt), 32'(base));
      check_eq("bp_m0_waits", 32'(ram_if.a_valid), 32'd0);
      check_eq("bp_m1_d_valid", 32'(m1_if.d_valid), 32'd1);
      d_rdy_mode[1] = 1;
      run_until_done(base + 2, 40, "bp_done");
      if (served.size() >= 2) begin
         check_eq("bp_order_m1", 32'(served[served.size() - 2]), 32'd1);
         check_eq("bp_order_m0", 32'(served[$]), 32'd0);
      end

      // reset in the middle of D_PHASE
      d_rdy_mode[0] = 0;
      issue_req(0, TL_OP_GET, 32'h0000_0300, 32'h0);
      run_until_phase(M_D, 20, "mrst_reach_d");
      #1;
      check_eq("mrst_pre_d_valid", 32'(m0_if.d_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_d_valid", 32'({m1_if.d_valid, m0_if.d_valid}), 32'd0);
      check_eq("mrst_ram_d_ready", 32'(ram_if.d_ready), 32'd0);
      check_eq("mrst_ram_a_valid", 32'(ram_if.a_valid), 32'd0);
      check_eq("mrst_a_ready", 32'({m1_if.a_ready, m0_if.a_ready}), 32'd0);
      clear_model();
      drive_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      d_rdy_mode[0] = -1; d_rdy_mode[1] = -1; delay_mode = -1; a_rdy_mode = -1;
      req_left[0] = 1; req_left[1] = 1;
      base = done_cnt;
      run_until_done(base + 2, 60, "mrst_after_done");
      if (served.size() > 0) check_eq("mrst_first_gnt", 32'(served[0]), 32'd0);

      // random traffic including abandoned requests
      rnd_gen = 1; drop_pct = 5;
      repeat (2000) tick();
      rnd_gen = 0; drop_pct = 0;
      for (int n = 0; n < 300 && (pend[0] || pend[1] || mph != M_IDLE); n++) tick();
      check_eq("drain_idle", 32'(pend[0] || pend[1] || mph != M_IDLE), 32'd0);

      // fixed-priority instance ran alongside with both ports always requesting
      check_eq("fp_transactions", 32'(fp_hs >= 8), 32'd1);
      check_eq("fp_m1_never", 32'(fp_m1_gnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
